// File: rtl/pcpi_op1_fp32_host_if.sv
// Bundle of the PCPI co-processor port and the fp32 dot-product engine
// STB/BUSY handshake.
//   master : the host bridge (drives PCPI responses and engine operands/strobe)
//   slave  : the environment (core side and engine side)
interface pcpi_op1_fp32_host_if;
   logic        pcpi_valid;
   logic [31:0] pcpi_insn;
   logic [31:0] pcpi_rs1;
   logic [31:0] pcpi_rs2;
   logic        pcpi_wr;
   logic [31:0] pcpi_rd;
   logic        pcpi_wait;
   logic        pcpi_ready;

   logic [31:0] op_input_a;
   logic [31:0] op_input_b;
   logic [31:0] op_input_c;
   logic [31:0] op_input_d;
   logic        op_input_STB;
   logic        op_BUSY;
   logic [31:0] op_result;
   logic        op_output_STB;
   logic        op_output_module_BUSY;

   modport master (
      input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
      output op_input_a, op_input_b, op_input_c, op_input_d, op_input_STB,
      input  op_BUSY, op_result, op_output_STB,
      output op_output_module_BUSY
   );

   modport slave (
      output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
      input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
      input  op_input_a, op_input_b, op_input_c, op_input_d, op_input_STB,
      output op_BUSY, op_result, op_output_STB,
      input  op_output_module_BUSY
   );
endinterface

// File: rtl/pcpi_op1_fp32_host.sv
// Host-side initiator for the fp32 dot-product engine (a*b + c*d).
// Decodes custom-0 PCPI instructions: LDAB/LDCD load operand pairs, RUN
// launches the engine and returns its result in rd, STAT returns the run
// counter. Producer on the engine input handshake, consumer on its output.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (engine shares it)
//   bus  : PCPI port and engine handshake (master modport)
//
// state    | meaning
// IDLE     | waiting for a claimed instruction
// ISSUE    | RUN accepted; waiting for any stale engine busy to clear
// STROBE   | op_input_STB high until the engine signals busy
// WAIT_RES | consumer ready; waiting for the engine result strobe
// ACK      | result captured; waiting for the result strobe to drop
// RESP     | pcpi_ready pulse
// HOLD     | one dead cycle while the core drops pcpi_valid
module pcpi_op1_fp32_host #(
   parameter logic [6:0] OPCODE = 7'b0001011,
   parameter logic [6:0] FUNCT7 = 7'b0101000
) (
   input logic                    clk,
   input logic                    rst,
   pcpi_op1_fp32_host_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE, ISSUE, STROBE, WAIT_RES, ACK, RESP, HOLD
   } state_t;

   state_t      r_state;
   logic [31:0] r_a, r_b, r_c, r_d;
   logic        r_stb;
   logic        r_out_busy;
   logic        r_wr;
   logic [31:0] r_rd;
   logic        r_wait;
   logic        r_ready;
   logic [15:0] r_run_cnt;

   logic        w_match;
   logic [2:0]  w_funct3;
   logic        w_eng_active;

   assign w_match      = bus.pcpi_valid
                         && (bus.pcpi_insn[6:0] == OPCODE)
                         && (bus.pcpi_insn[31:25] == FUNCT7);
   assign w_funct3     = bus.pcpi_insn[14:12];
   assign w_eng_active = !(r_state inside {IDLE, RESP, HOLD});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_c        <= '0;
         r_d        <= '0;
         r_stb      <= 1'b0;
         r_out_busy <= 1'b1;
         r_wr       <= 1'b0;
         r_rd       <= '0;
         r_wait     <= 1'b0;
         r_ready    <= 1'b0;
         r_run_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_match) begin
                  case (w_funct3)
                     3'b000: begin
                        r_a     <= bus.pcpi_rs1;
                        r_b     <= bus.pcpi_rs2;
                        r_wr    <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= RESP;
                     end
                     3'b001: begin
                        r_c     <= bus.pcpi_rs1;
                        r_d     <= bus.pcpi_rs2;
                        r_wr    <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= RESP;
                     end
                     3'b010: begin
                        r_wait  <= 1'b1;
                        r_state <= ISSUE;
                     end
                     3'b011: begin
                        r_rd    <= {15'b0, w_eng_active, r_run_cnt};
                        r_wr    <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= RESP;
                     end
                     default: ;
                  endcase
               end
            end
            // A busy left high by the previous run must clear before strobing.
            ISSUE: begin
               if (!bus.op_BUSY) begin
                  r_stb   <= 1'b1;
                  r_state <= STROBE;
               end
            end
            STROBE: begin
               if (bus.op_BUSY) begin
                  r_stb      <= 1'b0;
                  r_out_busy <= 1'b0;
                  r_state    <= WAIT_RES;
               end
            end
            WAIT_RES: begin
               if (bus.op_output_STB && !r_out_busy) begin
                  r_rd    <= bus.op_result;
                  r_wr    <= 1'b1;
                  r_state <= ACK;
               end
            end
            // Stay not-busy until the engine drops its strobe so the result
            // is consumed exactly once.
            ACK: begin
               if (!bus.op_output_STB) begin
                  r_out_busy <= 1'b1;
                  r_run_cnt  <= r_run_cnt + 16'd1;
                  r_wait     <= 1'b0;
                  r_ready    <= 1'b1;
                  r_state    <= RESP;
               end
            end
            RESP: begin
               r_ready <= 1'b0;
               r_wait  <= 1'b0;
               r_state <= HOLD;
            end
            HOLD: begin
               r_wr    <= 1'b0;
               r_rd    <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.pcpi_wr               = r_wr;
   assign bus.pcpi_rd               = r_rd;
   assign bus.pcpi_wait             = r_wait;
   assign bus.pcpi_ready            = r_ready;
   assign bus.op_input_a            = r_a;
   assign bus.op_input_b            = r_b;
   assign bus.op_input_c            = r_c;
   assign bus.op_input_d            = r_d;
   assign bus.op_input_STB          = r_stb;
   assign bus.op_output_module_BUSY = r_out_busy;

endmodule

// File: tb/tb_pcpi_op1_fp32_host.sv
module tb_pcpi_op1_fp32_host;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   pcpi_op1_fp32_host_if bus ();

   pcpi_op1_fp32_host dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] F7 = 7'b0101000;

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2);
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = mk(F7, f3);
      bus.pcpi_rs1   = rs1;
      bus.pcpi_rs2   = rs2;
   endtask

   initial begin
      bus.pcpi_valid    = 1'b0;
      bus.pcpi_insn     = '0;
      bus.pcpi_rs1      = '0;
      bus.pcpi_rs2      = '0;
      bus.op_BUSY       = 1'b0;
      bus.op_result     = '0;
      bus.op_output_STB = 1'b0;

      // reset state
      tick(); tick();
      chk("rst_ready", bus.pcpi_ready, 0);
      chk("rst_wait", bus.pcpi_wait, 0);
      chk("rst_wr", bus.pcpi_wr, 0);
      chk("rst_rd", bus.pcpi_rd, 0);
      chk("rst_stb", bus.op_input_STB, 0);
      chk("rst_obusy", bus.op_output_module_BUSY, 1);
      chk("rst_a", bus.op_input_a, 0);
      chk("rst_d", bus.op_input_d, 0);
      rst = 1'b0;
      tick();

      // LDAB 2.0 / 3.0, latency 1
      issue(3'b000, 32'h40000000, 32'h40400000);
      tick();
      chk("ldab_ready", bus.pcpi_ready, 1);
      chk("ldab_wr", bus.pcpi_wr, 0);
      chk("ldab_wait", bus.pcpi_wait, 0);
      chk("ldab_a", bus.op_input_a, 32'h40000000);
      chk("ldab_b", bus.op_input_b, 32'h40400000);
      bus.pcpi_valid = 1'b0;
      tick();
      chk("ldab_ready_drop", bus.pcpi_ready, 0);
      tick();

      // LDCD 1.0 / 0.5
      issue(3'b001, 32'h3F800000, 32'h3F000000);
      tick();
      chk("ldcd_ready", bus.pcpi_ready, 1);
      chk("ldcd_c", bus.op_input_c, 32'h3F800000);
      chk("ldcd_d", bus.op_input_d, 32'h3F000000);
      bus.pcpi_valid = 1'b0;
      tick(); tick();

      // RUN with a stale engine busy held 3 cycles into ISSUE
      bus.op_BUSY = 1'b1;
      issue(3'b010, 32'h0, 32'h0);
      tick();
      chk("run_wait", bus.pcpi_wait, 1);
      chk("run_ready0", bus.pcpi_ready, 0);
      chk("issue_stb0", bus.op_input_STB, 0);
      tick();
      chk("issue_stb1", bus.op_input_STB, 0);
      tick();
      chk("issue_stb2", bus.op_input_STB, 0);
      bus.op_BUSY = 1'b0;
      tick();
      chk("strobe_stb", bus.op_input_STB, 1);
      tick();
      chk("strobe_hold", bus.op_input_STB, 1);
      bus.op_BUSY = 1'b1;
      tick();
      chk("strobe_drop", bus.op_input_STB, 0);
      chk("wait_obusy", bus.op_output_module_BUSY, 0);
      chk("wait_wait", bus.pcpi_wait, 1);
      tick();
      chk("frozen_c", bus.op_input_c, 32'h3F800000);
      chk("frozen_a", bus.op_input_a, 32'h40000000);
      // engine presents 2*3 + 1*0.5 = 6.5, strobe held 4 cycles
      bus.op_BUSY       = 1'b0;
      bus.op_result     = 32'h40D00000;
      bus.op_output_STB = 1'b1;
      tick();
      chk("cap_rd", bus.pcpi_rd, 32'h40D00000);
      chk("cap_wr", bus.pcpi_wr, 1);
      chk("cap_ready", bus.pcpi_ready, 0);
      bus.op_result = 32'hDEADBEEF;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ack_obusy", bus.op_output_module_BUSY, 0);
         chk("ack_rd_once", bus.pcpi_rd, 32'h40D00000);
         chk("ack_ready", bus.pcpi_ready, 0);
         chk("ack_wait", bus.pcpi_wait, 1);
      end
      bus.op_output_STB = 1'b0;
      tick();
      chk("run_ready", bus.pcpi_ready, 1);
      chk("run_rd", bus.pcpi_rd, 32'h40D00000);
      chk("run_wr", bus.pcpi_wr, 1);
      chk("run_wait_clr", bus.pcpi_wait, 0);
      chk("run_obusy", bus.op_output_module_BUSY, 1);
      bus.pcpi_valid = 1'b0;
      tick();
      chk("run_single_pulse", bus.pcpi_ready, 0);
      tick();

      // STAT after one run
      issue(3'b011, 32'h0, 32'h0);
      tick();
      chk("stat1_ready", bus.pcpi_ready, 1);
      chk("stat1_wr", bus.pcpi_wr, 1);
      chk("stat1_rd", bus.pcpi_rd, 32'h00000001);
      bus.pcpi_valid = 1'b0;
      tick(); tick();

      // spurious result strobe while idle is ignored
      bus.op_result     = 32'h12345678;
      bus.op_output_STB = 1'b1;
      tick(); tick();
      chk("spur_obusy", bus.op_output_module_BUSY, 1);
      chk("spur_rd", bus.pcpi_rd, 0);
      chk("spur_wr", bus.pcpi_wr, 0);
      bus.op_output_STB = 1'b0;
      tick();

      // wrong funct7, then unsupported funct3: never claimed
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = mk(7'h00, 3'b000);
      bus.pcpi_rs1   = 32'hAAAAAAAA;
      bus.pcpi_rs2   = 32'h55555555;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("f7_idle", {bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr}, 0);
      end
      chk("f7_a_kept", bus.op_input_a, 32'h40000000);
      bus.pcpi_insn = mk(F7, 3'b101);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("f3_idle", {bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr}, 0);
      end
      bus.pcpi_valid = 1'b0;
      tick();

      // reset during WAIT_RES
      issue(3'b010, 32'h0, 32'h0);
      tick();
      tick();
      chk("r2_stb", bus.op_input_STB, 1);
      bus.op_BUSY = 1'b1;
      tick();
      chk("r2_waitres", bus.op_output_module_BUSY, 0);
      bus.pcpi_valid = 1'b0;
      bus.op_BUSY    = 1'b0;
      rst = 1'b1;
      tick();
      chk("r2_stb_clr", bus.op_input_STB, 0);
      chk("r2_obusy", bus.op_output_module_BUSY, 1);
      chk("r2_wait", bus.pcpi_wait, 0);
      chk("r2_a", bus.op_input_a, 0);
      rst = 1'b0;
      tick();
      issue(3'b011, 32'h0, 32'h0);
      tick();
      chk("stat0_ready", bus.pcpi_ready, 1);
      chk("stat0_rd", bus.pcpi_rd, 0);
      bus.pcpi_valid = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
